// File: rtl/multi_sensor_sampler.sv
// Round-robin SPI sensor scanner with per-channel timeout, a FWFT sample FIFO
// drained over valid/ready, and a latest-value register per channel for display.
//
// Ports: clk_i/rst_i (async, active-low); mode_i, trig_i, clear_i control;
// start_o/done_i/data_i to the sensor cores; drain_* to the SD side;
// disp_sel_i/disp_data_o for the display; count_o/full_o/empty_o/busy_o/
// overflow_o/timeout_o status.
module multi_sensor_sampler #(
  parameter int N_CH        = 4,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 512,
  parameter int PERIOD_CYC  = 10000,
  parameter int TIMEOUT_CYC = 4096,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int AW   = $clog2(DEPTH),
  localparam int EW   = CH_W + 1 + DATA_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     mode_i,
  input  logic                     trig_i,
  input  logic                     clear_i,
  output logic [N_CH-1:0]          start_o,
  input  logic [N_CH-1:0]          done_i,
  input  logic [N_CH*DATA_W-1:0]   data_i,
  output logic                     drain_valid_o,
  output logic [EW-1:0]            drain_data_o,
  input  logic                     drain_ready_i,
  input  logic [CH_W-1:0]          disp_sel_i,
  output logic [DATA_W-1:0]        disp_data_o,
  output logic [AW:0]              count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     busy_o,
  output logic                     overflow_o,
  output logic                     timeout_o
);

  localparam int PW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [PW-1:0] PER_LAST = PW'(PERIOD_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_CH - 1);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT, S_STORE, S_NEXT
  } state_t;

  state_t state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              pend_q, pend_d;
  logic [PW-1:0]     per_q, per_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [DATA_W-1:0] smp_q, smp_d;
  logic              flag_q, flag_d;
  logic [N_CH-1:0]   start_q, start_d;
  logic              ovf_q, ovf_d;
  logic              tof_q, tof_d;
  logic [AW-1:0]     wr_q, wr_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] last_q [N_CH];
  logic [DATA_W-1:0] last_d [N_CH];
  logic [EW-1:0]     mem [DEPTH];

  logic tick, set_tmo, push, pop, full, empty, wr_en;
  logic [CH_W-1:0] ch_nx;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign push  = (state_q == S_STORE);
  assign pop   = !empty && drain_ready_i;
  // A full FIFO still takes the push when the head leaves the same cycle.
  assign wr_en = push && (!full || pop);
  assign tick  = !mode_i && (per_q == PER_LAST);
  assign ch_nx = ch_q + CH_W'(1);

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    pend_d  = pend_q;
    per_d   = per_q;
    tmo_d   = tmo_q;
    smp_d   = smp_q;
    flag_d  = flag_q;
    start_d = '0;
    set_tmo = 1'b0;
    if (!mode_i) per_d = tick ? '0 : per_q + PW'(1);
    // Only one tick can be remembered while a scan is running.
    if (tick && state_q != S_IDLE) pend_d = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if ((!mode_i && (tick || pend_q)) || (mode_i && trig_i)) begin
          state_d    = S_START;
          ch_d       = '0;
          pend_d     = 1'b0;
          start_d[0] = 1'b1;
        end
      end
      S_START: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_i[ch_q]) begin
          smp_d   = data_i[int'(ch_q)*DATA_W +: DATA_W];
          flag_d  = 1'b0;
          state_d = S_STORE;
        end else if (tmo_q == TMO_LAST) begin
          smp_d   = '0;
          flag_d  = 1'b1;
          set_tmo = 1'b1;
          state_d = S_STORE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_STORE: state_d = S_NEXT;
      S_NEXT: begin
        if (ch_q == CH_LAST) begin
          state_d = S_IDLE;
        end else begin
          ch_d           = ch_nx;
          start_d[ch_nx] = 1'b1;
          state_d        = S_START;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_d  = wr_q + AW'(wr_en);
    rd_d  = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW + 1)'(wr_en) - (AW + 1)'(pop);
    // A concurrent set beats clear_i.
    ovf_d = (push && full && !pop) ? 1'b1 : (clear_i ? 1'b0 : ovf_q);
    tof_d = set_tmo ? 1'b1 : (clear_i ? 1'b0 : tof_q);
    last_d = last_q;
    if (push && !flag_q) last_d[ch_q] = smp_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      pend_q  <= 1'b0;
      per_q   <= '0;
      tmo_q   <= '0;
      smp_q   <= '0;
      flag_q  <= 1'b0;
      start_q <= '0;
      ovf_q   <= 1'b0;
      tof_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < N_CH; i++) last_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      pend_q  <= pend_d;
      per_q   <= per_d;
      tmo_q   <= tmo_d;
      smp_q   <= smp_d;
      flag_q  <= flag_d;
      start_q <= start_d;
      ovf_q   <= ovf_d;
      tof_q   <= tof_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Storage array carries no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_q] <= {ch_q, flag_q, smp_q};
  end

  assign start_o       = start_q;
  assign drain_valid_o = !empty;
  assign drain_data_o  = empty ? '0 : mem[rd_q];
  assign disp_data_o   = (int'(disp_sel_i) < N_CH) ? last_q[disp_sel_i] : '0;
  assign count_o       = cnt_q;
  assign full_o        = full;
  assign empty_o       = empty;
  assign busy_o        = (state_q != S_IDLE);
  assign overflow_o    = ovf_q;
  assign timeout_o     = tof_q;

endmodule

// File: tb/tb_multi_sensor_sampler.sv
// Scoreboard bench for multi_sensor_sampler: directed scans, expected FIFO
// entries queued by stimulus and checked by a drain-side monitor.
module tb_multi_sensor_sampler;
  localparam int N_CH = 4;
  localparam int DW   = 8;
  localparam int EW   = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mode = 1'b1;
  logic trig = 1'b0;
  logic clear = 1'b0;
  logic [N_CH-1:0] start_o;
  logic [N_CH-1:0] done = '0;
  logic [N_CH*DW-1:0] data = '0;
  logic drain_valid;
  logic [EW-1:0] drain_data;
  logic drain_ready = 1'b0;
  logic [1:0] disp_sel = '0;
  logic [DW-1:0] disp_data;
  logic [3:0] count;
  logic full, empty, busy, overflow, timeout;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int cd [N_CH];
  logic [7:0] base = 8'h10;
  logic [N_CH-1:0] silent = '0;
  logic [EW-1:0] exp_q [$];
  logic track = 1'b0;
  int maxcnt = 0;

  multi_sensor_sampler #(
    .N_CH(4), .DATA_W(8), .DEPTH(8),
    .PERIOD_CYC(100), .TIMEOUT_CYC(16)
  ) dut (
    .clk_i(clk), .rst_i(rst_n), .mode_i(mode), .trig_i(trig),
    .clear_i(clear), .start_o(start_o), .done_i(done), .data_i(data),
    .drain_valid_o(drain_valid), .drain_data_o(drain_data),
    .drain_ready_i(drain_ready), .disp_sel_i(disp_sel),
    .disp_data_o(disp_data), .count_o(count), .full_o(full),
    .empty_o(empty), .busy_o(busy), .overflow_o(overflow),
    .timeout_o(timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Sensor cores: answer base+ch five cycles after start unless silenced.
  always @(negedge clk) begin
    done = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (!rst_n) begin
        cd[c] = 0;
      end else begin
        if (cd[c] == 1) begin
          done[c] = 1'b1;
          data[c*DW +: DW] = base + 8'(c);
        end
        if (cd[c] > 0) cd[c]--;
        if (start_o[c] && !silent[c]) cd[c] = 5;
      end
    end
  end

  // Monitor: every accepted head entry must match the scoreboard front.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n && drain_valid && drain_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL drain_unexpected got=%h", drain_data);
      end else begin
        e = exp_q.pop_front();
        if (drain_data !== e) begin
          failures++;
          $display("FAIL drain_entry got=%h exp=%h", drain_data, e);
        end
      end
    end
    if (track && int'(count) > maxcnt) maxcnt = int'(count);
  end

  function automatic logic [EW-1:0] mk(input int ch, input bit f,
                                       input logic [7:0] d);
    logic [1:0] c2;
    c2 = ch[1:0];
    return {c2, f, d};
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic push_scan(input logic [7:0] b);
    for (int c = 0; c < N_CH; c++) exp_q.push_back(mk(c, 1'b0, b + 8'(c)));
  endtask

  task automatic do_trig();
    @(posedge clk); #1 trig = 1'b1;
    @(posedge clk); #1 trig = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("scan_done", int'(busy), 0);
  endtask

  task automatic wait_start(input int c, output int t);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!start_o[c] && n < 400);
    check("start_seen", int'(start_o[c]), 1);
    t = cyc;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
  endtask

  initial begin
    int t0, t1, t2, n;
    repeat (3) @(negedge clk);
    check("rst_empty", int'(empty), 1);
    check("rst_count", int'(count), 0);
    check("rst_start", int'(start_o), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_flags", int'({full, overflow, timeout, drain_valid}), 0);
    check("rst_drain_data", int'(drain_data), 0);
    check("rst_disp", int'(disp_data), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Manual scan with latency check on the first start pulse.
    drain_ready = 1'b1;
    base = 8'h10;
    push_scan(8'h10);
    do_trig();
    @(negedge clk);
    check("start_latency", int'(start_o), 1);
    check("busy_in_scan", int'(busy), 1);
    wait_idle();
    for (int c = 0; c < N_CH; c++) begin
      disp_sel = 2'(c);
      #1 check("disp_scan1", int'(disp_data), 'h10 + c);
    end

    // Channel 2 silent: timeout entry 18 cycles after its start pulse.
    base = 8'h20;
    silent = 4'b0100;
    exp_q.push_back(mk(0, 1'b0, 8'h20));
    exp_q.push_back(mk(1, 1'b0, 8'h21));
    exp_q.push_back(mk(2, 1'b1, 8'h00));
    exp_q.push_back(mk(3, 1'b0, 8'h23));
    do_trig();
    wait_start(2, t0);
    n = 0;
    while (!drain_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", cyc - t0, 18);
    wait_idle();
    check("timeout_flag", int'(timeout), 1);
    disp_sel = 2'd2;
    #1 check("disp_ch2_kept", int'(disp_data), 'h12);
    disp_sel = 2'd3;
    #1 check("disp_ch3_new", int'(disp_data), 'h23);
    silent = '0;
    pulse_clear();
    @(negedge clk);
    check("timeout_cleared", int'(timeout), 0);
    check("no_overflow", int'(overflow), 0);

    // Continuous mode: scans every 100 cycles, occupancy stays at most 1.
    base = 8'h30;
    push_scan(8'h30);
    push_scan(8'h30);
    push_scan(8'h30);
    maxcnt = 0;
    track = 1'b1;
    @(posedge clk); #1 mode = 1'b0;
    wait_start(0, t0);
    wait_start(0, t1);
    wait_start(0, t2);
    mode = 1'b1;
    wait_idle();
    track = 1'b0;
    check("period_1", t1 - t0, 100);
    check("period_2", t2 - t1, 100);
    check("max_count", maxcnt, 1);

    // Fill with ready low: 12 pushes, 8 kept.
    drain_ready = 1'b0;
    base = 8'h40;
    push_scan(8'h40);
    do_trig();
    wait_idle();
    base = 8'h48;
    push_scan(8'h48);
    do_trig();
    wait_idle();
    base = 8'h50;
    do_trig();
    wait_idle();
    check("fill_count", int'(count), 8);
    check("fill_full", int'(full), 1);
    check("fill_overflow", int'(overflow), 1);
    check("fill_head", int'(drain_data), int'(mk(0, 1'b0, 8'h40)));

    // Full FIFO, ready only in the STORE cycle of channel 0.
    pulse_clear();
    @(negedge clk);
    check("ovf_cleared", int'(overflow), 0);
    base = 8'h58;
    exp_q.push_back(mk(0, 1'b0, 8'h58));
    do_trig();
    wait_start(0, t0);
    repeat (6) @(posedge clk);
    #1 drain_ready = 1'b1;
    @(posedge clk); #1 drain_ready = 1'b0;
    @(negedge clk);
    check("pushpop_count", int'(count), 8);
    check("pushpop_no_ovf", int'(overflow), 0);
    wait_idle();
    check("dropped_ovf", int'(overflow), 1);
    drain_ready = 1'b1;
    n = 0;
    while (!empty && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drained_count", int'(count), 0);
    check("sb_empty_1", exp_q.size(), 0);

    // Reset in the middle of a WAIT with entries held in the FIFO.
    drain_ready = 1'b0;
    base = 8'h60;
    do_trig();
    wait_idle();
    silent = 4'b0001;
    do_trig();
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    disp_sel = 2'd0;
    #1;
    check("mid_rst_count", int'(count), 0);
    check("mid_rst_empty", int'(empty), 1);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_flags", int'({overflow, timeout, drain_valid}), 0);
    check("mid_rst_disp", int'(disp_data), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_start", int'(start_o), 0);
    end
    silent = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    drain_ready = 1'b1;
    base = 8'h70;
    push_scan(8'h70);
    do_trig();
    wait_idle();
    repeat (3) @(negedge clk);
    check("sb_empty_2", exp_q.size(), 0);
    check("final_empty", int'(empty), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
